// File: rtl/csr_timer_int_ctrl_pkg.sv
// Shared definitions for the timer/interrupt CSR block.
// CSR numbers, TCFG field positions, ESTAT.IS bit indices, the
// register-select enum used by the read/write decode, and the masked-write helper.
package csr_timer_int_ctrl_pkg;

    // CSR numbers owned or observed by this block
    localparam logic [13:0] CSR_ESTAT = 14'h05;
    localparam logic [13:0] CSR_TID   = 14'h40;
    localparam logic [13:0] CSR_TCFG  = 14'h41;
    localparam logic [13:0] CSR_TVAL  = 14'h42;
    localparam logic [13:0] CSR_TICLR = 14'h44;

    // TCFG field positions
    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;

    // ESTAT.IS bit indices
    localparam int IS_HW_LSB = 2;
    localparam int IS_HW_MSB = 9;
    localparam int IS_RSVD   = 10;
    localparam int IS_TI     = 11;
    localparam int IS_IPI    = 12;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TID,
        SEL_TCFG,
        SEL_TVAL,
        SEL_TICLR
    } csr_sel_e;

    // Registers this block answers for on the CSR read port.
    // ESTAT is deliberately absent: the CSR file owns its read mux.
    function automatic csr_sel_e csr_decode(input logic [13:0] num);
        case (num)
            CSR_TID:   return SEL_TID;
            CSR_TCFG:  return SEL_TCFG;
            CSR_TVAL:  return SEL_TVAL;
            CSR_TICLR: return SEL_TICLR;
            default:   return SEL_NONE;
        endcase
    endfunction

    // Bits selected by the mask take the new value; the rest keep the old one.
    function automatic logic [31:0] masked_write(input logic [31:0] wmask,
                                                 input logic [31:0] wvalue,
                                                 input logic [31:0] old);
        return (wmask & wvalue) | (~wmask & old);
    endfunction

endpackage

// File: rtl/csr_down_timer.sv
// Down-counting timer behind TCFG/TVAL.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   tcfg_we           TCFG write strobe (already decoded)
//   wmask, wvalue     write mask / data, low TVAL_W bits
//   tcfg              current TCFG register
//   tval              current TVAL counter
//   ti_event          1 in the cycle the counter expires (tval == 0 with En)
module csr_down_timer
    import csr_timer_int_ctrl_pkg::*;
#(
    parameter int TVAL_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tcfg_we,
    input  logic [TVAL_W-1:0] wmask,
    input  logic [TVAL_W-1:0] wvalue,
    output logic [TVAL_W-1:0] tcfg,
    output logic [TVAL_W-1:0] tval,
    output logic              ti_event
);

    localparam logic [TVAL_W-1:0] TVAL_STOP = '1;

    logic [TVAL_W-1:0] tcfg_new;
    logic [TVAL_W-1:0] tval_nxt;

    function automatic logic [TVAL_W-1:0] reload_of(input logic [TVAL_W-1:0] cfg);
        return {cfg[TVAL_W-1:TCFG_INITVAL_LSB], 2'b00};
    endfunction

    assign tcfg_new = (wmask & wvalue) | (~wmask & tcfg);

    // A TCFG write restarts the count and masks any expiry in the same cycle.
    // All-ones is the parked state of a finished one-shot: it never decrements.
    always_comb begin
        tval_nxt = tval;
        ti_event = 1'b0;
        if (tcfg_we) begin
            tval_nxt = reload_of(tcfg_new);
        end else if (tcfg[TCFG_EN]) begin
            if (tval == '0) begin
                ti_event = 1'b1;
                tval_nxt = tcfg[TCFG_PERIODIC] ? reload_of(tcfg) : TVAL_STOP;
            end else if (tval != TVAL_STOP) begin
                tval_nxt = tval - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg <= '0;
            tval <= TVAL_STOP;
        end else begin
            if (tcfg_we) begin
                tcfg <= tcfg_new;
            end
            tval <= tval_nxt;
        end
    end

endmodule

// File: rtl/csr_timer_int_ctrl.sv
// Timer / interrupt CSR slice: TID, TCFG, TVAL, TICLR, ESTAT.IS, the 64-bit
// stable counter and the registered interrupt request.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   csr_we                 qualified CSR write strobe from writeback
//   csr_num                CSR number for read and write
//   csr_wmask, csr_wvalue  write mask / data
//   crmd_ie, ecfg_lie      global and local interrupt enables
//   hw_int, ipi_int        level interrupt sources
//   csr_hit, csr_rvalue    combinational read port (0 when not hit)
//   estat_is               ESTAT.IS[12:0] for the CSR file's ESTAT read
//   timer64                stable counter
//   tid                    TID value for rdcntid
//   has_int                registered interrupt request
module csr_timer_int_ctrl
    import csr_timer_int_ctrl_pkg::*;
#(
    parameter logic [31:0] TID_RESET = 32'h0,
    parameter int          TVAL_W    = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_we,
    input  logic [13:0] csr_num,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        crmd_ie,
    input  logic [12:0] ecfg_lie,
    input  logic [7:0]  hw_int,
    input  logic        ipi_int,
    output logic        csr_hit,
    output logic [31:0] csr_rvalue,
    output logic [12:0] estat_is,
    output logic [63:0] timer64,
    output logic [31:0] tid,
    output logic        has_int
);

    csr_sel_e          csr_sel;
    logic              tid_we;
    logic              tcfg_we;
    logic              ticlr_we;
    logic              estat_we;
    logic              ti_clear;
    logic              ti_event;
    logic              pend;
    logic [TVAL_W-1:0] tcfg;
    logic [TVAL_W-1:0] tval;
    logic [31:0]       tcfg_ext;
    logic [31:0]       tval_ext;
    logic [63:0]       stable_cnt;
    logic [12:0]       is_q;

    assign csr_sel  = csr_decode(csr_num);
    assign csr_hit  = (csr_sel != SEL_NONE);

    // TVAL is read-only, so it has no write strobe.
    assign tid_we   = csr_we && (csr_sel == SEL_TID);
    assign tcfg_we  = csr_we && (csr_sel == SEL_TCFG);
    assign ticlr_we = csr_we && (csr_sel == SEL_TICLR);
    assign estat_we = csr_we && (csr_num == CSR_ESTAT);
    assign ti_clear = ticlr_we && csr_wmask[0] && csr_wvalue[0];

    csr_down_timer #(
        .TVAL_W(TVAL_W)
    ) u_down_timer (
        .clk      (clk),
        .resetn   (resetn),
        .tcfg_we  (tcfg_we),
        .wmask    (csr_wmask[TVAL_W-1:0]),
        .wvalue   (csr_wvalue[TVAL_W-1:0]),
        .tcfg     (tcfg),
        .tval     (tval),
        .ti_event (ti_event)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 64'd1;
        end
    end

    assign timer64 = stable_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid <= TID_RESET;
        end else if (tid_we) begin
            tid <= masked_write(csr_wmask, csr_wvalue, tid);
        end
    end

    // Hardware and IPI lines are sampled every cycle. A timer expiry beats
    // a same-cycle TICLR so an interrupt is never lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_q <= '0;
        end else begin
            if (estat_we) begin
                is_q[1:0] <= (csr_wmask[1:0] & csr_wvalue[1:0]) | (~csr_wmask[1:0] & is_q[1:0]);
            end
            is_q[IS_HW_MSB:IS_HW_LSB] <= hw_int;
            is_q[IS_RSVD]             <= 1'b0;
            is_q[IS_TI]               <= ti_event | (is_q[IS_TI] & ~ti_clear);
            is_q[IS_IPI]              <= ipi_int;
        end
    end

    assign estat_is = is_q;

    // Request drops one cycle after crmd_ie falls on exception entry;
    // no explicit acknowledge exists.
    assign pend = crmd_ie & (|(is_q & ecfg_lie));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            has_int <= 1'b0;
        end else begin
            has_int <= pend;
        end
    end

    always_comb begin
        tcfg_ext = '0;
        tval_ext = '0;
        tcfg_ext[TVAL_W-1:0] = tcfg;
        tval_ext[TVAL_W-1:0] = tval;
    end

    // Current state only; a same-cycle write is not forwarded.
    always_comb begin
        csr_rvalue = '0;
        case (csr_sel)
            SEL_TID:   csr_rvalue = tid;
            SEL_TCFG:  csr_rvalue = tcfg_ext;
            SEL_TVAL:  csr_rvalue = tval_ext;
            default:   csr_rvalue = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_timer_int_ctrl.sv
// Bench for csr_timer_int_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural model of the CSR rules.
module tb_csr_timer_int_ctrl;

    localparam logic [13:0] A_ESTAT = 14'h05;
    localparam logic [13:0] A_TID   = 14'h40;
    localparam logic [13:0] A_TCFG  = 14'h41;
    localparam logic [13:0] A_TVAL  = 14'h42;
    localparam logic [13:0] A_TICLR = 14'h44;
    localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        crmd_ie;
    logic [12:0] ecfg_lie;
    logic [7:0]  hw_int;
    logic        ipi_int;
    logic        csr_hit;
    logic [31:0] csr_rvalue;
    logic [12:0] estat_is;
    logic [63:0] timer64;
    logic [31:0] tid;
    logic        has_int;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [63:0] m_t64;
    logic [31:0] m_tid, m_tcfg, m_tval;
    logic [12:0] m_is;
    logic        m_has;
    // Next reference state
    logic [63:0] n_t64;
    logic [31:0] n_tid, n_tcfg, n_tval;
    logic [12:0] n_is;
    logic        n_has;

    always #5 clk = ~clk;

    csr_timer_int_ctrl #(
        .TID_RESET(32'h0),
        .TVAL_W   (32)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .csr_we     (csr_we),
        .csr_num    (csr_num),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .crmd_ie    (crmd_ie),
        .ecfg_lie   (ecfg_lie),
        .hw_int     (hw_int),
        .ipi_int    (ipi_int),
        .csr_hit    (csr_hit),
        .csr_rvalue (csr_rvalue),
        .estat_is   (estat_is),
        .timer64    (timer64),
        .tid        (tid),
        .has_int    (has_int)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old);
        return (csr_wmask & csr_wvalue) | (~csr_wmask & old);
    endfunction

    function automatic logic [31:0] reload(input logic [31:0] cfg);
        return {cfg[31:2], 2'b00};
    endfunction

    task automatic model_reset();
        m_t64 = '0; m_tid = 32'h0; m_tcfg = '0; m_tval = ONES; m_is = '0; m_has = 1'b0;
    endtask

    // Next state from the current reference state and the inputs about to be sampled.
    task automatic model_step();
        logic ev;
        ev    = 1'b0;
        n_t64 = m_t64 + 64'd1;
        n_tid = (csr_we && csr_num == A_TID) ? merge(m_tid) : m_tid;
        n_tcfg = m_tcfg;
        n_tval = m_tval;
        if (csr_we && csr_num == A_TCFG) begin
            n_tcfg = merge(m_tcfg);
            n_tval = reload(n_tcfg);
        end else if (m_tcfg[0]) begin
            if (m_tval == 0) begin
                ev = 1'b1;
                n_tval = m_tcfg[1] ? reload(m_tcfg) : ONES;
            end else if (m_tval != ONES) begin
                n_tval = m_tval - 1;
            end
        end
        n_is = m_is;
        if (csr_we && csr_num == A_ESTAT)
            n_is[1:0] = (csr_wmask[1:0] & csr_wvalue[1:0]) | (~csr_wmask[1:0] & m_is[1:0]);
        n_is[9:2] = hw_int;
        n_is[10]  = 1'b0;
        if (ev)
            n_is[11] = 1'b1;
        else if (csr_we && csr_num == A_TICLR && csr_wmask[0] && csr_wvalue[0])
            n_is[11] = 1'b0;
        n_is[12] = ipi_int;
        n_has = crmd_ie && ((m_is & ecfg_lie) != 0);
    endtask

    function automatic logic [31:0] model_read(input logic [13:0] n);
        case (n)
            A_TID:   return m_tid;
            A_TCFG:  return m_tcfg;
            A_TVAL:  return m_tval;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_hit(input logic [13:0] n);
        return (n == A_TID) || (n == A_TCFG) || (n == A_TVAL) || (n == A_TICLR);
    endfunction

    task automatic compare_all();
        check("timer64", timer64, m_t64);
        check("tid", {32'h0, tid}, {32'h0, m_tid});
        check("estat_is", {51'h0, estat_is}, {51'h0, m_is});
        check("has_int", {63'h0, has_int}, {63'h0, m_has});
        check("csr_hit", {63'h0, csr_hit}, {63'h0, model_hit(csr_num)});
        check("csr_rvalue", {32'h0, csr_rvalue}, {32'h0, model_read(csr_num)});
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        m_t64 = n_t64; m_tid = n_tid; m_tcfg = n_tcfg; m_tval = n_tval; m_is = n_is; m_has = n_has;
        compare_all();
    endtask

    // Called 1 time unit after a rising edge; reset is checked before the next edge.
    task automatic do_reset();
        csr_num = A_TVAL;
        resetn  = 1'b0;
        #2;
        check("rst_tval", {32'h0, csr_rvalue}, {32'h0, ONES});
        check("rst_timer64", timer64, 64'h0);
        check("rst_has_int", {63'h0, has_int}, 64'h0);
        check("rst_estat_is", {51'h0, estat_is}, 64'h0);
        check("rst_tid", {32'h0, tid}, 64'h0);
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic write(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v;
        cycle();
        csr_we = 1'b0;
    endtask

    // Cycles until TI is seen set, bounded.
    task automatic wait_ti(output int k);
        k = 0;
        while (!estat_is[11] && k < 100) begin
            cycle();
            k++;
        end
    endtask

    initial begin
        int k;
        resetn = 1'b0; csr_we = 1'b0; csr_num = A_TVAL; csr_wmask = '0; csr_wvalue = '0;
        crmd_ie = 1'b0; ecfg_lie = '0; hw_int = '0; ipi_int = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        csr_num = A_TCFG;
        #1;
        check("rst_tcfg", {32'h0, csr_rvalue}, 64'h0);

        // One-shot: R = 0x14, expiry 21 cycles after the write
        crmd_ie = 1'b1; ecfg_lie = 13'h800;
        write(A_TCFG, ONES, 32'h15);
        csr_num = A_TVAL;
        wait_ti(k);
        check("oneshot_latency", k, 21);
        check("oneshot_tval_stop", {32'h0, csr_rvalue}, {32'h0, ONES});
        cycle();
        check("oneshot_has_int", {63'h0, has_int}, 64'h1);
        repeat (5) cycle();
        check("oneshot_tval_hold", {32'h0, csr_rvalue}, {32'h0, ONES});

        // Periodic: R = 8, expiry every 9 cycles
        do_reset();
        write(A_TCFG, ONES, 32'h0B);
        wait_ti(k);
        check("periodic_first", k, 9);
        write(A_TICLR, ONES, 32'h1);
        check("ticlr_clears", {63'h0, estat_is[11]}, 64'h0);
        wait_ti(k);
        check("periodic_period", k, 8);
        write(A_TICLR, ONES, 32'h1);
        check("ticlr_clears2", {63'h0, estat_is[11]}, 64'h0);
        repeat (7) cycle();
        write(A_TICLR, ONES, 32'h1);
        check("event_beats_clear", {63'h0, estat_is[11]}, 64'h1);
        csr_num = A_TICLR;
        #1;
        check("ticlr_reads_zero", {32'h0, csr_rvalue}, 64'h0);
        check("ticlr_hit", {63'h0, csr_hit}, 64'h1);
        csr_num = A_ESTAT;
        #1;
        check("estat_not_hit", {63'h0, csr_hit}, 64'h0);

        // Interrupt gating
        do_reset();
        hw_int = 8'h08; ecfg_lie = 13'h020; crmd_ie = 1'b1;
        cycle();
        check("gate_is5", {63'h0, estat_is[5]}, 64'h1);
        check("gate_has_int_lat1", {63'h0, has_int}, 64'h0);
        cycle();
        check("gate_has_int_lat2", {63'h0, has_int}, 64'h1);
        crmd_ie = 1'b0;
        cycle();
        check("gate_ie_drop", {63'h0, has_int}, 64'h0);
        repeat (3) cycle();
        check("gate_ie_off", {63'h0, has_int}, 64'h0);

        // Reset mid-count with tval = 5 and an active request
        crmd_ie = 1'b1;
        write(A_TCFG, ONES, 32'h09);
        csr_num = A_TVAL;
        repeat (3) cycle();
        check("midcount_tval5", {32'h0, csr_rvalue}, 64'h5);
        check("midcount_has_int", {63'h0, has_int}, 64'h1);
        do_reset();
        hw_int = 8'h0; ecfg_lie = 13'h0;

        // Masked writes
        write(A_TID, ONES, 32'h1234_5678);
        check("tid_full", {32'h0, tid}, 64'h1234_5678);
        write(A_TID, 32'hFFFF_0000, 32'hAAAA_0000);
        check("tid_masked", {32'h0, tid}, 64'hAAAA_5678);
        write(A_TVAL, ONES, 32'h0);
        csr_num = A_TVAL;
        #1;
        check("tval_readonly", {32'h0, csr_rvalue}, {32'h0, ONES});

        // Stable counter wrap
        force dut.stable_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.stable_cnt;
        m_t64 = 64'hFFFF_FFFF_FFFF_FFFE;
        check("wrap_preload", timer64, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle();
        cycle();
        check("wrap_zero", timer64, 64'h0);
        cycle();
        check("wrap_one", timer64, 64'h1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            csr_we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 6))
                0: csr_num = A_TID;
                1: csr_num = A_TCFG;
                2: csr_num = A_TVAL;
                3: csr_num = A_TICLR;
                4: csr_num = A_ESTAT;
                5: csr_num = A_TVAL;
                default: csr_num = 14'($urandom);
            endcase
            csr_wmask  = ($urandom_range(0, 1) == 1) ? ONES : $urandom;
            csr_wvalue = (csr_num == A_TCFG) ? 32'($urandom_range(0, 127)) : $urandom;
            if (csr_num == A_TCFG && $urandom_range(0, 3) != 0) csr_we = 1'b0;
            crmd_ie  = ($urandom_range(0, 3) != 0);
            ecfg_lie = 13'($urandom);
            hw_int   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
            ipi_int  = ($urandom_range(0, 4) == 0);
            cycle();
        end
        csr_we = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
